// File: rtl/tlu_trigger_fanout_pkg.sv
// Shared definitions for the TLU trigger fanout block: register map, FSM encoding and
// the power-on pulse length.
package tlu_trigger_fanout_pkg;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StTrig     = 2'd1,
    StWaitBusy = 2'd2
  } state_e;

  localparam logic [7:0] TrigLenRst = 8'd8;

  localparam logic [3:0] OffVersion  = 4'd0;
  localparam logic [3:0] OffConf     = 4'd1;
  localparam logic [3:0] OffBeamMask = 4'd2;
  localparam logic [3:0] OffDutMask  = 4'd3;
  localparam logic [3:0] OffTrigLen  = 4'd4;
  localparam logic [3:0] OffRstPulse = 4'd5;
  localparam logic [3:0] OffTid0     = 4'd8;
  localparam logic [3:0] OffTid1     = 4'd9;
  localparam logic [3:0] OffTid2     = 4'd10;
  localparam logic [3:0] OffTid3     = 4'd11;
  localparam logic [3:0] OffSkip0    = 4'd12;
  localparam logic [3:0] OffSkip1    = 4'd13;

endpackage

// File: rtl/bus_to_ip.sv
// Bus slave adapter: address window decode, strobes to the IP, and read data driven on
// BUS_DATA for the single cycle after an accepted BUS_RD.
module bus_to_ip #(
  parameter int unsigned BASEADDR  = 0,
  parameter int unsigned HIGHADDR  = 0,
  parameter int unsigned ABUSWIDTH = 16,
  parameter int unsigned DBUSWIDTH = 8
) (
  input  logic                 BUS_CLK,
  input  logic                 BUS_RST,
  input  logic                 BUS_RD,
  input  logic                 BUS_WR,
  input  logic [ABUSWIDTH-1:0] BUS_ADD,
  inout  wire  [DBUSWIDTH-1:0] BUS_DATA,
  output logic                 IP_RD,
  output logic                 IP_WR,
  output logic [ABUSWIDTH-1:0] IP_ADD,
  output logic [DBUSWIDTH-1:0] IP_DATA_IN,
  input  logic [DBUSWIDTH-1:0] IP_DATA_OUT
);

  localparam logic [ABUSWIDTH:0] Span = (ABUSWIDTH + 1)'(HIGHADDR - BASEADDR + 1);

  logic cs;
  logic rd_q;

  // Offset compare avoids a constant-true lower bound when BASEADDR is zero.
  assign IP_ADD     = BUS_ADD - ABUSWIDTH'(BASEADDR);
  assign cs         = {1'b0, IP_ADD} < Span;
  assign IP_RD      = cs & BUS_RD;
  assign IP_WR      = cs & BUS_WR;
  assign IP_DATA_IN = BUS_DATA;

  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) rd_q <= 1'b0;
    else         rd_q <= IP_RD;
  end

  assign BUS_DATA = rd_q ? IP_DATA_OUT : {DBUSWIDTH{1'bz}};

endmodule

// File: rtl/tlu_trigger_fanout_core.sv
// Beam coincidence, trigger FSM with DUT busy handshake, trigger/skip counters and the
// independent DUT reset pulse generator.
module tlu_trigger_fanout_core
  import tlu_trigger_fanout_pkg::*;
#(
  parameter int unsigned DutCh  = 6,
  parameter int unsigned BeamCh = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              mode_i,
  input  logic [BeamCh-1:0] beam_mask_i,
  input  logic [BeamCh-1:0] beam_trigger_i,
  input  logic [DutCh-1:0]  dut_mask_i,
  input  logic [DutCh-1:0]  dut_busy_i,
  input  logic [7:0]        trig_len_i,
  input  logic              rst_pulse_wr_i,
  input  logic [DutCh-1:0]  rst_pulse_bits_i,
  input  logic              skip_clr_i,
  output logic [DutCh-1:0]  dut_trigger_o,
  output logic [DutCh-1:0]  dut_reset_o,
  output logic              trigger_accepted_o,
  output logic [31:0]       trigger_id_o,
  output logic [15:0]       skip_cnt_o
);

  logic [BeamCh-1:0] beam_act;
  logic              coin, coin_q, req, busy;
  logic [7:0]        len_m1;
  state_e            state_q, state_d;
  logic [7:0]        trig_cnt_q, trig_cnt_d;
  logic [DutCh-1:0]  trig_mask_q, trig_mask_d;
  logic              accept, skip, accepted_q;
  logic [31:0]       trigger_id_q, trigger_id_d;
  logic [15:0]       skip_q, skip_d;
  logic [7:0]        rst_cnt_q, rst_cnt_d;
  logic [DutCh-1:0]  rst_q, rst_d;

  assign beam_act = beam_trigger_i & beam_mask_i;
  assign coin     = (beam_mask_i != '0) &&
                    (mode_i ? (beam_act == beam_mask_i) : (beam_act != '0));
  assign req      = en_i && coin && !coin_q;
  assign busy     = (dut_busy_i & dut_mask_i) != '0;
  // A length of zero behaves as one cycle.
  assign len_m1   = (trig_len_i == 8'd0) ? 8'd0 : trig_len_i - 8'd1;

  always_comb begin
    state_d     = state_q;
    trig_cnt_d  = trig_cnt_q;
    trig_mask_d = trig_mask_q;
    accept      = 1'b0;
    skip        = 1'b0;
    case (state_q)
      StIdle: begin
        if (req) begin
          if (busy) begin
            skip = 1'b1;
          end else begin
            accept      = 1'b1;
            state_d     = StTrig;
            trig_cnt_d  = len_m1;
            trig_mask_d = dut_mask_i;
          end
        end
      end
      StTrig: begin
        skip = req;
        if (trig_cnt_q == 8'd0) state_d = StWaitBusy;
        else                    trig_cnt_d = trig_cnt_q - 8'd1;
      end
      StWaitBusy: begin
        skip = req;
        if (!busy) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    trigger_id_d = accept ? trigger_id_q + 32'd1 : trigger_id_q;
    skip_d       = skip_q;
    if (skip_clr_i)                     skip_d = 16'd0;
    else if (skip && skip_q != 16'hFFFF) skip_d = skip_q + 16'd1;
  end

  // A new write restarts the length counter and merges its bits into any active pulse.
  always_comb begin
    rst_d     = rst_q;
    rst_cnt_d = rst_cnt_q;
    if (rst_pulse_wr_i && rst_pulse_bits_i != '0) begin
      rst_d     = rst_q | rst_pulse_bits_i;
      rst_cnt_d = len_m1;
    end else if (rst_q != '0) begin
      if (rst_cnt_q == 8'd0) rst_d = '0;
      else                   rst_cnt_d = rst_cnt_q - 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      coin_q       <= 1'b0;
      trig_cnt_q   <= 8'd0;
      trig_mask_q  <= '0;
      accepted_q   <= 1'b0;
      trigger_id_q <= 32'd0;
      skip_q       <= 16'd0;
      rst_cnt_q    <= 8'd0;
      rst_q        <= '0;
    end else begin
      state_q      <= state_d;
      coin_q       <= coin;
      trig_cnt_q   <= trig_cnt_d;
      trig_mask_q  <= trig_mask_d;
      accepted_q   <= accept;
      trigger_id_q <= trigger_id_d;
      skip_q       <= skip_d;
      rst_cnt_q    <= rst_cnt_d;
      rst_q        <= rst_d;
    end
  end

  assign dut_trigger_o      = (state_q == StTrig) ? trig_mask_q : '0;
  assign dut_reset_o        = rst_q;
  assign trigger_accepted_o = accepted_q;
  assign trigger_id_o       = trigger_id_q;
  assign skip_cnt_o         = skip_q;

endmodule

// File: rtl/tlu_trigger_fanout.sv
// TLU trigger fanout: register file and read mux on the BUS_ADD/BUS_DATA bus around the
// trigger core.
module tlu_trigger_fanout
  import tlu_trigger_fanout_pkg::*;
#(
  parameter int unsigned BASEADDR  = 'h0000,
  parameter int unsigned HIGHADDR  = 'h0000,
  parameter int unsigned ABUSWIDTH = 16,
  parameter int unsigned DUT_CH    = 6,
  parameter int unsigned BEAM_CH   = 4,
  parameter logic [7:0]  VERSION   = 8'h01
) (
  input  logic                 BUS_CLK,
  input  logic                 BUS_RST,
  input  logic [ABUSWIDTH-1:0] BUS_ADD,
  inout  wire  [7:0]           BUS_DATA,
  input  logic                 BUS_RD,
  input  logic                 BUS_WR,
  input  logic [BEAM_CH-1:0]   BEAM_TRIGGER,
  input  logic [DUT_CH-1:0]    DUT_BUSY,
  output logic [DUT_CH-1:0]    DUT_TRIGGER,
  output logic [DUT_CH-1:0]    DUT_RESET,
  output logic                 TRIGGER_ACCEPTED,
  output logic [31:0]          TRIGGER_ID
);

  logic                 ip_rd, ip_wr, hit, soft_rst, rst_all;
  logic [ABUSWIDTH-1:0] ip_add;
  logic [3:0]           lo;
  logic [7:0]           ip_data_in, rd_mux, rd_data_q;
  logic [1:0]           conf_q;
  logic [BEAM_CH-1:0]   beam_mask_q;
  logic [DUT_CH-1:0]    dut_mask_q;
  logic [7:0]           trig_len_q;
  logic [31:0]          id_shadow_q;
  logic [15:0]          skip_cnt;

  bus_to_ip #(
    .BASEADDR (BASEADDR),
    .HIGHADDR (HIGHADDR),
    .ABUSWIDTH(ABUSWIDTH),
    .DBUSWIDTH(8)
  ) u_bus_to_ip (
    .BUS_CLK    (BUS_CLK),
    .BUS_RST    (BUS_RST),
    .BUS_RD     (BUS_RD),
    .BUS_WR     (BUS_WR),
    .BUS_ADD    (BUS_ADD),
    .BUS_DATA   (BUS_DATA),
    .IP_RD      (ip_rd),
    .IP_WR      (ip_wr),
    .IP_ADD     (ip_add),
    .IP_DATA_IN (ip_data_in),
    .IP_DATA_OUT(rd_data_q)
  );

  assign hit      = ip_add[ABUSWIDTH-1:4] == '0;
  assign lo       = ip_add[3:0];
  assign soft_rst = ip_wr && hit && (lo == OffVersion);
  assign rst_all  = BUS_RST || soft_rst;

  always_comb begin
    rd_mux = 8'h00;
    if (hit) begin
      case (lo)
        OffVersion:  rd_mux = VERSION;
        OffConf:     rd_mux = {6'b0, conf_q};
        OffBeamMask: rd_mux = 8'(beam_mask_q);
        OffDutMask:  rd_mux = 8'(dut_mask_q);
        OffTrigLen:  rd_mux = trig_len_q;
        OffTid0:     rd_mux = TRIGGER_ID[7:0];
        OffTid1:     rd_mux = id_shadow_q[15:8];
        OffTid2:     rd_mux = id_shadow_q[23:16];
        OffTid3:     rd_mux = id_shadow_q[31:24];
        OffSkip0:    rd_mux = skip_cnt[7:0];
        OffSkip1:    rd_mux = skip_cnt[15:8];
        default:     rd_mux = 8'h00;
      endcase
    end
  end

  always_ff @(posedge BUS_CLK) begin
    if (rst_all) begin
      conf_q      <= 2'b00;
      beam_mask_q <= '0;
      dut_mask_q  <= '0;
      trig_len_q  <= TrigLenRst;
      id_shadow_q <= 32'd0;
      rd_data_q   <= 8'h00;
    end else begin
      if (ip_wr && hit) begin
        case (lo)
          OffConf:     conf_q      <= ip_data_in[1:0];
          OffBeamMask: beam_mask_q <= ip_data_in[BEAM_CH-1:0];
          OffDutMask:  dut_mask_q  <= ip_data_in[DUT_CH-1:0];
          OffTrigLen:  trig_len_q  <= ip_data_in;
          default: ;
        endcase
      end
      if (ip_rd) rd_data_q <= rd_mux;
      // Reading the low byte freezes the full count so the upper bytes stay coherent.
      if (ip_rd && hit && lo == OffTid0) id_shadow_q <= TRIGGER_ID;
    end
  end

  tlu_trigger_fanout_core #(
    .DutCh (DUT_CH),
    .BeamCh(BEAM_CH)
  ) u_core (
    .clk_i             (BUS_CLK),
    .rst_i             (rst_all),
    .en_i              (conf_q[0]),
    .mode_i            (conf_q[1]),
    .beam_mask_i       (beam_mask_q),
    .beam_trigger_i    (BEAM_TRIGGER),
    .dut_mask_i        (dut_mask_q),
    .dut_busy_i        (DUT_BUSY),
    .trig_len_i        (trig_len_q),
    .rst_pulse_wr_i    (ip_wr && hit && lo == OffRstPulse),
    .rst_pulse_bits_i  (ip_data_in[DUT_CH-1:0]),
    .skip_clr_i        (ip_wr && hit && lo == OffSkip0),
    .dut_trigger_o     (DUT_TRIGGER),
    .dut_reset_o       (DUT_RESET),
    .trigger_accepted_o(TRIGGER_ACCEPTED),
    .trigger_id_o      (TRIGGER_ID),
    .skip_cnt_o        (skip_cnt)
  );

endmodule

// File: tb/tb_tlu_trigger_fanout.sv
// Bench for tlu_trigger_fanout: coincidence vector table, directed corner sequences and
// randomized traffic against a cycle-level reference model.
module tb_tlu_trigger_fanout;

  logic        BUS_CLK = 1'b0;
  logic        BUS_RST;
  logic [15:0] BUS_ADD;
  wire  [7:0]  BUS_DATA;
  logic        BUS_RD, BUS_WR;
  logic [3:0]  BEAM_TRIGGER;
  logic [5:0]  DUT_BUSY;
  logic [5:0]  DUT_TRIGGER, DUT_RESET;
  logic        TRIGGER_ACCEPTED;
  logic [31:0] TRIGGER_ID;

  logic [7:0] tb_data;
  logic       tb_drive;
  assign BUS_DATA = tb_drive ? tb_data : 8'bz;

  always #5 BUS_CLK = ~BUS_CLK;

  tlu_trigger_fanout #(
    .BASEADDR (32'h1000),
    .HIGHADDR (32'h100F),
    .ABUSWIDTH(16),
    .DUT_CH   (6),
    .BEAM_CH  (4),
    .VERSION  (8'h01)
  ) dut (
    .BUS_CLK         (BUS_CLK),
    .BUS_RST         (BUS_RST),
    .BUS_ADD         (BUS_ADD),
    .BUS_DATA        (BUS_DATA),
    .BUS_RD          (BUS_RD),
    .BUS_WR          (BUS_WR),
    .BEAM_TRIGGER    (BEAM_TRIGGER),
    .DUT_BUSY        (DUT_BUSY),
    .DUT_TRIGGER     (DUT_TRIGGER),
    .DUT_RESET       (DUT_RESET),
    .TRIGGER_ACCEPTED(TRIGGER_ACCEPTED),
    .TRIGGER_ID      (TRIGGER_ID)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge BUS_CLK);
  endtask

  task automatic wr(input logic [3:0] off, input logic [7:0] d);
    BUS_ADD  = 16'h1000 + {12'h000, off};
    tb_data  = d;
    tb_drive = 1'b1;
    BUS_WR   = 1'b1;
    @(negedge BUS_CLK);
    BUS_WR   = 1'b0;
    tb_drive = 1'b0;
  endtask

  task automatic rd(input logic [3:0] off, output logic [7:0] d);
    BUS_ADD = 16'h1000 + {12'h000, off};
    BUS_RD  = 1'b1;
    @(negedge BUS_CLK);
    BUS_RD = 1'b0;
    d = BUS_DATA;
    @(negedge BUS_CLK);
  endtask

  task automatic beam_pulse(input logic [3:0] b);
    BEAM_TRIGGER = b;
    @(negedge BUS_CLK);
    BEAM_TRIGGER = 4'h0;
  endtask

  // Reference model: tracks remaining trigger cycles and the busy wait by spec rules.
  bit          model_on = 1'b0;
  bit          m_mode;
  logic [3:0]  m_bm;
  logic [5:0]  m_dm;
  int          m_len;
  int          m_left;
  bit          m_wait;
  logic [5:0]  m_mask;
  logic [31:0] m_id;
  int          m_skip;
  bit          m_acc;
  bit          m_prev;

  always @(posedge BUS_CLK) begin
    if (model_on) begin
      logic [3:0] act;
      bit coin, req, busy, skip;
      act  = BEAM_TRIGGER & m_bm;
      coin = (m_bm != 4'h0) && (m_mode ? (act == m_bm) : (act != 4'h0));
      req  = coin && !m_prev;
      busy = (DUT_BUSY & m_dm) != 6'h0;
      skip = 1'b0;
      m_acc = 1'b0;
      if (m_left > 0) begin
        skip = req;
        m_left--;
        if (m_left == 0) m_wait = 1'b1;
      end else if (m_wait) begin
        skip = req;
        if (!busy) m_wait = 1'b0;
      end else if (req) begin
        if (busy) skip = 1'b1;
        else begin
          m_acc  = 1'b1;
          m_left = (m_len == 0) ? 1 : m_len;
          m_mask = m_dm;
          m_id   = m_id + 1;
        end
      end
      if (skip && m_skip < 65535) m_skip++;
      m_prev = coin;
    end
  end

  typedef struct {
    logic       en;
    logic       mode;
    logic [3:0] mask;
    logic [3:0] beam;
    int         exp_acc;
  } coin_vec_t;

  coin_vec_t   cv[10];
  logic [7:0]  d, d1, d2, d3;
  int          hi, acc, first_hi;
  logic [31:0] exp_id;

  initial begin
    cv[0] = '{1'b1, 1'b0, 4'h3, 4'h2, 1};
    cv[1] = '{1'b1, 1'b1, 4'h3, 4'h1, 0};
    cv[2] = '{1'b1, 1'b1, 4'h3, 4'h3, 1};
    cv[3] = '{1'b1, 1'b0, 4'h0, 4'hF, 0};
    cv[4] = '{1'b1, 1'b1, 4'h0, 4'hF, 0};
    cv[5] = '{1'b1, 1'b0, 4'h5, 4'hA, 0};
    cv[6] = '{1'b1, 1'b1, 4'h5, 4'hF, 1};
    cv[7] = '{1'b1, 1'b0, 4'h8, 4'h8, 1};
    cv[8] = '{1'b0, 1'b0, 4'hF, 4'hF, 0};
    cv[9] = '{1'b1, 1'b1, 4'hF, 4'h7, 0};

    BUS_RST = 1'b1; BUS_ADD = 16'h0; BUS_RD = 1'b0; BUS_WR = 1'b0;
    tb_data = 8'h0; tb_drive = 1'b0; BEAM_TRIGGER = 4'h0; DUT_BUSY = 6'h0;
    tick(3);
    BUS_RST = 1'b0;
    tick(1);

    check("rst_trig", 32'(DUT_TRIGGER), 32'h0);
    check("rst_dutreset", 32'(DUT_RESET), 32'h0);
    check("rst_acc", 32'(TRIGGER_ACCEPTED), 32'h0);
    check("rst_id", TRIGGER_ID, 32'h0);
    rd(4'd0, d); check("version", 32'(d), 32'h01);
    rd(4'd4, d); check("trig_len_rst", 32'(d), 32'h08);
    rd(4'd1, d); check("conf_rst", 32'(d), 32'h00);
    wr(4'd2, 8'hFF); rd(4'd2, d); check("beam_mask_width", 32'(d), 32'h0F);
    wr(4'd3, 8'hFF); rd(4'd3, d); check("dut_mask_width", 32'(d), 32'h3F);
    wr(4'd6, 8'hAA); rd(4'd6, d); check("unmapped", 32'(d), 32'h00);

    // OR mode single trigger: timing and length.
    wr(4'd1, 8'h01); wr(4'd2, 8'h03); wr(4'd3, 8'h3F); wr(4'd4, 8'd4);
    BEAM_TRIGGER = 4'h2;
    hi = 0; acc = 0; first_hi = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge BUS_CLK);
      if (i == 0) BEAM_TRIGGER = 4'h0;
      if (DUT_TRIGGER == 6'h3F) begin
        hi++;
        if (first_hi < 0) first_hi = i;
      end
      if (TRIGGER_ACCEPTED) acc++;
    end
    check("or_first_hi", 32'(first_hi), 32'd0);
    check("or_len", 32'(hi), 32'd4);
    check("or_acc", 32'(acc), 32'd1);
    check("or_id", TRIGGER_ID, 32'd1);
    exp_id = 32'd1;

    // Coincidence table.
    wr(4'd4, 8'd2);
    foreach (cv[k]) begin
      wr(4'd1, {6'b0, cv[k].mode, cv[k].en});
      wr(4'd2, {4'h0, cv[k].mask});
      tick(2);
      BEAM_TRIGGER = cv[k].beam;
      acc = 0;
      for (int i = 0; i < 8; i++) begin
        @(negedge BUS_CLK);
        if (i == 0) BEAM_TRIGGER = 4'h0;
        if (TRIGGER_ACCEPTED) acc++;
      end
      exp_id = exp_id + 32'(cv[k].exp_acc);
      check($sformatf("coin_vec%0d_acc", k), 32'(acc), 32'(cv[k].exp_acc));
      check($sformatf("coin_vec%0d_id", k), TRIGGER_ID, exp_id);
    end

    // Busy DUT masked in: all skipped; masked out: all accepted.
    wr(4'd1, 8'h01); wr(4'd2, 8'h01); wr(4'd3, 8'h04); wr(4'd12, 8'h00);
    DUT_BUSY = 6'h04;
    for (int i = 0; i < 3; i++) begin beam_pulse(4'h1); tick(8); end
    rd(4'd12, d); rd(4'd13, d1);
    check("busy_skip_cnt", 32'({d1, d}), 32'd3);
    check("busy_id", TRIGGER_ID, exp_id);
    wr(4'd3, 8'h03);
    for (int i = 0; i < 3; i++) begin beam_pulse(4'h1); tick(8); end
    exp_id = exp_id + 32'd3;
    check("unbusy_id", TRIGGER_ID, exp_id);
    DUT_BUSY = 6'h00;

    // Busy raised during TRIG holds the FSM in WAIT_BUSY.
    wr(4'd3, 8'h01); wr(4'd4, 8'd4); wr(4'd12, 8'h00);
    beam_pulse(4'h1);
    DUT_BUSY = 6'h01;
    tick(5); beam_pulse(4'h1); tick(6); beam_pulse(4'h1); tick(7);
    check("wait_no_trig", 32'(DUT_TRIGGER), 32'h0);
    DUT_BUSY = 6'h00;
    exp_id = exp_id + 32'd1;
    check("wait_id", TRIGGER_ID, exp_id);
    rd(4'd12, d); check("wait_skip", 32'(d), 32'd2);
    tick(2);
    beam_pulse(4'h1);
    exp_id = exp_id + 32'd1;
    check("after_busy_id", TRIGGER_ID, exp_id);
    tick(8);

    // Counter wrap.
    force dut.u_core.trigger_id_q = 32'hFFFF_FFFF;
    tick(1);
    release dut.u_core.trigger_id_q;
    check("preload", TRIGGER_ID, 32'hFFFF_FFFF);
    beam_pulse(4'h1);
    check("wrap", TRIGGER_ID, 32'h0);
    tick(8);

    // Shadow coherence across a byte carry.
    force dut.u_core.trigger_id_q = 32'h01FF_FFFF;
    tick(1);
    release dut.u_core.trigger_id_q;
    rd(4'd8, d);
    beam_pulse(4'h1); tick(8);
    check("carry_live", TRIGGER_ID, 32'h0200_0000);
    rd(4'd9, d1); rd(4'd10, d2); rd(4'd11, d3);
    check("shadow", {d3, d2, d1, d}, 32'h01FF_FFFF);

    // DUT reset pulses: zero length acts as one cycle, rewrite merges and restarts.
    wr(4'd4, 8'd0); wr(4'd5, 8'h21);
    check("rstp_val", 32'(DUT_RESET), 32'h21);
    hi = 0;
    for (int i = 0; i < 5; i++) begin @(negedge BUS_CLK); if (DUT_RESET != 6'h0) hi++; end
    check("rstp_len1", 32'(hi), 32'd0);
    rd(4'd5, d); check("rstp_read", 32'(d), 32'h0);
    wr(4'd4, 8'd3); wr(4'd5, 8'h01); tick(1); wr(4'd5, 8'h02);
    check("rstp_merge", 32'(DUT_RESET), 32'h03);
    hi = 0;
    for (int i = 0; i < 6; i++) begin @(negedge BUS_CLK); if (DUT_RESET != 6'h0) hi++; end
    check("rstp_restart", 32'(hi), 32'd2);

    // Bus reset in the middle of a trigger and a reset pulse.
    wr(4'd4, 8'd8); wr(4'd3, 8'h3F); wr(4'd5, 8'h3F);
    beam_pulse(4'h1); tick(2);
    check("mid_trig", 32'(DUT_TRIGGER), 32'h3F);
    BUS_RST = 1'b1;
    @(negedge BUS_CLK);
    BUS_RST = 1'b0;
    check("brst_trig", 32'(DUT_TRIGGER), 32'h0);
    check("brst_dutreset", 32'(DUT_RESET), 32'h0);
    check("brst_id", TRIGGER_ID, 32'h0);
    tick(1);

    // Randomized traffic against the reference model.
    for (int r = 0; r < 3; r++) begin
      wr(4'd0, 8'h00);
      check("soft_rst_id", TRIGGER_ID, 32'h0);
      m_mode = 1'($urandom_range(0, 1));
      m_bm   = 4'($urandom_range(1, 15));
      m_dm   = 6'($urandom_range(1, 63));
      m_len  = $urandom_range(0, 5);
      wr(4'd1, {6'b0, m_mode, 1'b1});
      wr(4'd2, {4'h0, m_bm});
      wr(4'd3, {2'b0, m_dm});
      wr(4'd4, 8'(m_len));
      m_left = 0; m_wait = 1'b0; m_mask = 6'h0; m_id = 32'h0;
      m_skip = 0; m_acc = 1'b0; m_prev = 1'b0;
      model_on = 1'b1;
      for (int c = 0; c < 400; c++) begin
        BEAM_TRIGGER = 4'($urandom);
        DUT_BUSY = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'h00;
        @(negedge BUS_CLK);
        check("rand_trig", 32'(DUT_TRIGGER), 32'((m_left > 0) ? m_mask : 6'h0));
        check("rand_acc", 32'(TRIGGER_ACCEPTED), 32'(m_acc));
        check("rand_id", TRIGGER_ID, m_id);
      end
      BEAM_TRIGGER = 4'h0; DUT_BUSY = 6'h00;
      tick(10);
      model_on = 1'b0;
      check("rand_final_id", TRIGGER_ID, m_id);
      rd(4'd12, d); rd(4'd13, d1);
      check("rand_skip", 32'({d1, d}), 32'(m_skip));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
